light_bar_scheduler: RTL



---
 rtl/light_bar_pkg.sv | 36 +++
 rtl/light_bar_scheduler_button_debouncer.sv | 54 +++++
 rtl/light_bar_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/light_bar_pkg.sv
// Shared types and constants for the light-bar pattern scheduler.
package light_bar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned NUM_PATTERNS = 4;
  localparam int unsigned PAT_W        = $clog2(NUM_PATTERNS);
  localparam int unsigned BCD_W        = 4;

  // One-hot enables in [0:3] order: bit 0 (leftmost) selects pattern 0.
  localparam logic [0:NUM_PATTERNS-1] PAT0 = 4'b1000;
  localparam logic [0:NUM_PATTERNS-1] PAT1 = 4'b0100;
  localparam logic [0:NUM_PATTERNS-1] PAT2 = 4'b0010;
  localparam logic [0:NUM_PATTERNS-1] PAT3 = 4'b0001;

  // Pattern index to one-hot enable vector.
  function automatic logic [0:NUM_PATTERNS-1] pat_onehot(input logic [PAT_W-1:0] pat);
    logic [0:NUM_PATTERNS-1] oh;
    case (pat)
      PAT_W'(1): oh = PAT1;
      PAT_W'(2): oh = PAT2;
      PAT_W'(3): oh = PAT3;
      default:   oh = PAT0;
    endcase
    return oh;
  endfunction

  // Next pattern index, wrapping from the last pattern back to 0.
  function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] pat);
    return (pat == PAT_W'(NUM_PATTERNS - 1)) ? '0 : pat + 1'b1;
  endfunction

endpackage

// File: rtl/light_bar_scheduler_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press event.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,      // raw button, active-low
  output logic pressed_o,    // debounced level, 1 = pressed
  output logic press_evt_o   // one cycle on released->pressed
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             stable_n_q, stable_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;

  // Accept the synced level once it has differed from the stable level
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d      = '0;
    stable_n_d = stable_n_q;
    evt_d      = 1'b0;
    if (sync_q[1] != stable_n_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_n_d = sync_q[1];
        evt_d      = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q     <= 2'b11;
      stable_n_q <= 1'b1;
      cnt_q      <= '0;
      evt_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_n_i};
      stable_n_q <= stable_n_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign pressed_o   = ~stable_n_q;
  assign press_evt_o = evt_q;

endmodule

// File: rtl/light_bar_scheduler.sv
// Light-bar sequencer: 1 Hz time base, manual/auto pattern stepping,
// long-press return to IDLE, one-hot enables and BCD pattern number.
module light_bar_scheduler
  import light_bar_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_TICKS      = 3,
  parameter int unsigned HOLD_TICKS      = 2
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    switch,
  input  logic                    iButton,
  output logic [0:NUM_PATTERNS-1] enables,
  output logic [BCD_W-1:0]        stateBCD,
  output logic                    timer
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DWELL_W = $clog2(AUTO_TICKS + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);

  logic                    btn_pressed, press_evt;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    timer_q, timer_d;
  logic                    sw_meta_q, sw_sync_q, sw_prev_q;
  state_e                  state_q, state_d;
  logic [PAT_W-1:0]        pat_q, pat_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    hold_fire;
  logic [0:NUM_PATTERNS-1] enables_q, enables_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i      (clock),
    .rst_n_i    (resetN),
    .btn_n_i    (iButton),
    .pressed_o  (btn_pressed),
    .press_evt_o(press_evt)
  );

  // Free-running prescaler; timer_q marks the cycle after the terminal count.
  always_comb begin
    presc_d = presc_q + 1'b1;
    timer_d = 1'b0;
    if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
      presc_d = '0;
      timer_d = 1'b1;
    end
  end

  // Count ticks of a continuous press; saturates so a hold fires only once.
  always_comb begin
    hold_d    = hold_q;
    hold_fire = 1'b0;
    if (!btn_pressed) begin
      hold_d = '0;
    end else if (timer_q && (hold_q < HOLD_W'(HOLD_TICKS))) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
        hold_fire = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; button beats the auto tick.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        pat_d   = '0;
        dwell_d = '0;
        if (press_evt) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (hold_fire) begin
          state_d = IDLE;
          pat_d   = '0;
          dwell_d = '0;
        end else if (press_evt) begin
          pat_d   = next_pat(pat_q);
          dwell_d = '0;
        end else if ((sw_sync_q != sw_prev_q) || !sw_sync_q) begin
          dwell_d = '0;
        end else if (timer_q) begin
          if (dwell_q == DWELL_W'(AUTO_TICKS - 1)) begin
            pat_d   = next_pat(pat_q);
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pat_d   = '0;
        dwell_d = '0;
      end
    endcase
    enables_d = (state_d == RUN) ? pat_onehot(pat_d) : '0;
    bcd_d     = (state_d == RUN) ? BCD_W'(pat_d) : '0;
  end

  // State, counters, switch synchronizer and output registers.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      presc_q   <= '0;
      timer_q   <= 1'b0;
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      sw_prev_q <= 1'b0;
      state_q   <= IDLE;
      pat_q     <= '0;
      dwell_q   <= '0;
      hold_q    <= '0;
      enables_q <= '0;
      bcd_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      state_q   <= state_d;
      pat_q     <= pat_d;
      dwell_q   <= dwell_d;
      hold_q    <= hold_d;
      enables_q <= enables_d;
      bcd_q     <= bcd_d;
    end
  end

  assign enables  = enables_q;
  assign stateBCD = bcd_q;
  assign timer    = timer_q;

endmodule
